pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx_pkg.sv | 22 ++
 rtl/prbs_lfsr.sv | 25 ++
 rtl/pattern_tx.sv | 139 +++++++++++++
 tb/tb_pattern_tx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// rtl/pattern_tx_pkg.sv - shared encodings and helpers for the pattern transmitter
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS     = 2'b00,
        MODE_PRBS_INV = 2'b01,
        MODE_ALT      = 2'b10,
        MODE_FIXED    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// rtl/prbs_lfsr.sv - Fibonacci LFSR, all-ones seed, MSB is the output bit
module prbs_lfsr #(
    parameter int POLY_LEN = 9,
    parameter int POLY_TAP = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic seed_load,
    input  logic advance,
    output logic bit_out
);

    logic [POLY_LEN-1:0] s;

    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            s <= '1;
        end else if (advance) begin
            s <= {s[POLY_LEN-2:0], s[POLY_LEN-1] ^ s[POLY_TAP-1]};
        end
    end

    assign bit_out = s[POLY_LEN-1];

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - framed serial test-pattern generator with bit-rate divider
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WORD_W      = 10,
    parameter int FRAME_WORDS = 20,
    parameter int POLY_LEN    = 9,
    parameter int POLY_TAP    = 5,
    parameter int DIV_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_start,
    input  logic [DIV_W-1:0]  speed_div,
    input  logic [1:0]        mode,
    input  logic [WORD_W-1:0] fixed_word,
    output logic              serial_out,
    output logic              bit_strobe,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = cnt_width(WORD_W);
    localparam int WW = cnt_width(FRAME_WORDS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

    state_e              state, state_nx;
    mode_e               mode_lat;
    logic [DIV_W-1:0]    div_lat;
    logic [DIV_W-1:0]    div_cnt;
    logic [WORD_W-1:0]   word_sr;
    logic [BW-1:0]       bit_cnt;
    logic [WW-1:0]       word_cnt;
    logic                alt_bit;
    logic                prbs_bit;
    logic                pattern_bit;
    logic                start_ok;
    logic                period_end;
    logic                frame_end;

    assign start_ok   = (state == ST_IDLE) && send_start;
    assign period_end = (state == ST_SHIFT) && (div_cnt == div_lat);
    assign frame_end  = period_end && (bit_cnt == BIT_LAST) && (word_cnt == WORD_LAST);

    prbs_lfsr #(
        .POLY_LEN (POLY_LEN),
        .POLY_TAP (POLY_TAP)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (start_ok),
        .advance   (period_end),
        .bit_out   (prbs_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame parameters are captured once at acceptance so mid-frame input changes are inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_lat <= MODE_PRBS;
            div_lat  <= '0;
            div_cnt  <= '0;
            word_sr  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            alt_bit  <= 1'b0;
        end else if (start_ok) begin
            mode_lat <= mode_e'(mode);
            div_lat  <= speed_div;
            div_cnt  <= '0;
            word_sr  <= fixed_word;
            bit_cnt  <= '0;
            word_cnt <= '0;
            alt_bit  <= 1'b1;
        end else if (period_end) begin
            div_cnt <= '0;
            alt_bit <= ~alt_bit;
            word_sr <= {word_sr[WORD_W-2:0], word_sr[WORD_W-1]};
            if (bit_cnt == BIT_LAST) begin
                bit_cnt  <= '0;
                word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (state == ST_SHIFT) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        pattern_bit = 1'b0;
        case (mode_lat)
            MODE_PRBS:     pattern_bit = prbs_bit;
            MODE_PRBS_INV: pattern_bit = ~prbs_bit;
            MODE_ALT:      pattern_bit = alt_bit;
            MODE_FIXED:    pattern_bit = word_sr[WORD_W-1];
            default:       pattern_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        serial_out = 1'b0;
        bit_strobe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (send_start) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy       = 1'b1;
                bit_strobe = (div_cnt == '0);
                serial_out = pattern_bit;
                if (frame_end) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nx   = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - directed scoreboard bench for pattern_tx
module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_start;
    logic [7:0] speed_div;
    logic [1:0] mode;
    logic [9:0] fixed_word;
    logic       serial_out;
    logic       bit_strobe;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    bit prbs[0:199];

    pattern_tx dut (
        .clk        (clk),
        .rst        (rst),
        .send_start (send_start),
        .speed_div  (speed_div),
        .mode       (mode),
        .fixed_word (fixed_word),
        .serial_out (serial_out),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: scoreboard filled from the reference stream, drained at each expected bit start.
    task automatic run_frame(input logic [1:0] m, input logic [7:0] div, input logic [9:0] fw,
                             input logic [9:0] first_word, input bit b2b, input bit disturb);
        int   period;
        logic [9:0] w0;
        bit   cur;
        period = int'(div) + 1;
        w0 = '0;
        cur = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 200; i++) begin
            case (m)
                2'b00:   exp_q.push_back(prbs[i]);
                2'b01:   exp_q.push_back(!prbs[i]);
                2'b10:   exp_q.push_back((i % 2) == 0);
                default: exp_q.push_back(fw[9 - (i % 10)]);
            endcase
        end
        if (!b2b) @(negedge clk);
        mode = m;
        speed_div = div;
        fixed_word = fw;
        send_start = 1'b1;
        for (int c = 0; c < 200 * period; c++) begin
            @(negedge clk);
            if (c == 0) send_start = 1'b0;
            if (disturb) begin
                if (c == 1) begin
                    mode = ~m;
                    speed_div = div + 8'd3;
                    fixed_word = ~fw;
                end
                if (c == 30) send_start = 1'b1;
                if (c == 31) send_start = 1'b0;
            end
            chk("busy", busy, 1);
            if ((c % period) == 0) begin
                chk("strobe_high", bit_strobe, 1);
                cur = exp_q.pop_front();
                if (c < 10 * period) w0 = {w0[8:0], serial_out};
            end else begin
                chk("strobe_low", bit_strobe, 0);
            end
            chk("serial", serial_out, cur);
        end
        chk("first_word", w0, first_word);
        @(negedge clk);
        chk("done_pulse", frame_done, 1);
        chk("done_busy", busy, 0);
        chk("done_serial", serial_out, 0);
        chk("done_strobe", bit_strobe, 0);
        if (disturb) send_start = 1'b1;
        @(negedge clk);
        send_start = 1'b0;
        chk("idle_done", frame_done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        // Reference PRBS: out[j+9] = out[j] ^ out[j+4], nine leading ones.
        for (int k = 0; k < 200; k++) begin
            prbs[k] = (k < 9) ? 1'b1 : (prbs[k-9] ^ prbs[k-5]);
        end

        rst = 1'b1;
        send_start = 1'b1;
        speed_div = '0;
        mode = 2'b00;
        fixed_word = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_serial", serial_out, 0);
            chk("rst_strobe", bit_strobe, 0);
            chk("rst_done", frame_done, 0);
        end
        rst = 1'b0;
        send_start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        run_frame(2'b00, 8'd0, 10'h000, 10'h3FE, 1'b0, 1'b0);
        run_frame(2'b01, 8'd4, 10'h000, 10'h001, 1'b0, 1'b1);
        run_frame(2'b11, 8'd1, 10'h2B5, 10'h2B5, 1'b0, 1'b1);
        run_frame(2'b10, 8'd2, 10'h000, 10'h2AA, 1'b0, 1'b1);
        run_frame(2'b00, 8'd0, 10'h000, 10'h3FE, 1'b0, 1'b0);
        run_frame(2'b00, 8'd0, 10'h000, 10'h3FE, 1'b1, 1'b0);

        // Abort at bit 57 with a one-cycle reset.
        @(negedge clk);
        mode = 2'b00;
        speed_div = 8'd0;
        send_start = 1'b1;
        for (int c = 0; c <= 57; c++) begin
            @(negedge clk);
            if (c == 0) send_start = 1'b0;
            chk("pre_abort_serial", serial_out, prbs[c]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_serial", serial_out, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_strobe", bit_strobe, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_done", frame_done, 0);
            chk("abort_idle_busy", busy, 0);
        end
        run_frame(2'b00, 8'd0, 10'h000, 10'h3FE, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
